// File: rtl/up_run_ctrl.sv
// up_run_ctrl: command-driven run sequencer for the up core (clock enable, stretched core reset, cycle count).
// Breakpoint support is compiled in only when UP_RUN_CTRL_BREAKPOINT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RST_SEQ   | core held in reset; counts RST_CYCLES after reset release
// IDLE      | waiting for a host command; core clock gated off
// RUN_FREE  | core enabled every cycle until halt (or breakpoint)
// RUN_N     | core enabled until remaining reaches 0, halt or breakpoint
// STEP      | core enabled for a single cycle
// DONE      | one-cycle done pulse, then back to IDLE
module up_run_ctrl #(
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 4,
  parameter int DEFAULT_RUN = 100,
  parameter int PC_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             soft_rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_op_in,
  input  logic [CNT_W-1:0] cycles_in,
  input  logic             halt_in,
`ifdef UP_RUN_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]  pc_in,
  input  logic [PC_W-1:0]  bp_addr_in,
  input  logic             bp_en_in,
  output logic             bp_hit_out,
`endif
  output logic             core_ce_out,
  output logic             core_rst_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [CNT_W-1:0] remaining_out
);

  localparam int RW = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  if (RST_CYCLES < 1 || PC_W < 1) begin : g_param_check
    $error("up_run_ctrl: RST_CYCLES and PC_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_RST_SEQ, S_IDLE, S_RUN_FREE, S_RUN_N, S_STEP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP, OP_RUN_FREE, OP_STEP, OP_RUN_N
  } op_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic          stop;

`ifdef UP_RUN_CTRL_BREAKPOINT_EN
  logic bp_match;
  assign bp_match = bp_en_in && (pc_in == bp_addr_in);
  assign stop     = halt_in || bp_match;
`else
  assign stop     = halt_in;
`endif

  always_ff @(posedge clk_in) begin
    // every enabled core cycle counts, including one cut short by halt or soft reset
    if (core_ce_out) cycle_cnt_out <= cycle_cnt_out + 1'b1;
    done_out <= 1'b0;

    if (rst_in || soft_rst_in) begin
      state         <= S_RST_SEQ;
      rst_cnt       <= RW'(RST_CYCLES);
      core_rst_out  <= 1'b1;
      core_ce_out   <= 1'b0;
      cmd_ready_out <= 1'b0;
      busy_out      <= 1'b1;
`ifdef UP_RUN_CTRL_BREAKPOINT_EN
      bp_hit_out    <= 1'b0;
`endif
      if (rst_in) begin
        cycle_cnt_out <= '0;
        remaining_out <= '0;
      end
    end else begin
      case (state)
        S_RST_SEQ: begin
          if (rst_cnt == '0) begin
            state         <= S_IDLE;
            core_rst_out  <= 1'b0;
            cmd_ready_out <= 1'b1;
            busy_out      <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_valid_in && cmd_op_in != OP_NOP) begin
            cmd_ready_out <= 1'b0;
            busy_out      <= 1'b1;
            core_ce_out   <= 1'b1;
`ifdef UP_RUN_CTRL_BREAKPOINT_EN
            bp_hit_out    <= 1'b0;
`endif
            case (cmd_op_in)
              OP_RUN_FREE: state <= S_RUN_FREE;
              OP_STEP:     state <= S_STEP;
              default: begin
                state         <= S_RUN_N;
                remaining_out <= (cycles_in == '0) ? CNT_W'(DEFAULT_RUN) : cycles_in;
              end
            endcase
          end
        end
        S_RUN_FREE: begin
          if (stop) begin
            state       <= S_DONE;
            core_ce_out <= 1'b0;
            done_out    <= 1'b1;
          end
        end
        S_RUN_N: begin
          remaining_out <= remaining_out - 1'b1;
          if (stop || remaining_out == CNT_W'(1)) begin
            state       <= S_DONE;
            core_ce_out <= 1'b0;
            done_out    <= 1'b1;
          end
        end
        S_STEP: begin
          state       <= S_DONE;
          core_ce_out <= 1'b0;
          done_out    <= 1'b1;
        end
        S_DONE: begin
          state         <= S_IDLE;
          cmd_ready_out <= 1'b1;
          busy_out      <= 1'b0;
        end
        default: begin
          state        <= S_RST_SEQ;
          rst_cnt      <= RW'(RST_CYCLES);
          core_rst_out <= 1'b1;
          core_ce_out  <= 1'b0;
          busy_out     <= 1'b1;
        end
      endcase
`ifdef UP_RUN_CTRL_BREAKPOINT_EN
      if ((state == S_RUN_FREE || state == S_RUN_N) && bp_match) bp_hit_out <= 1'b1;
`endif
    end
  end

endmodule
